// File: rtl/quad_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// quad_step_ctrl : quadrature encoder front end. Synchronises and filters
//                  A/B/Z, decodes x1/x2/x4 count strobes, index load, err.
//                  Optional macro QUAD_STEP_ERR_CNT_EN adds err_cnt[7:0].
// Revision 1.0 - initial release
// ============================================================================
module quad_step_ctrl #(
  parameter int W        = 16,
  parameter int FILT_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   mode,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         z_in,
  input  logic         index_en,
  input  logic [W-1:0] index_val,
  output logic         ce,
  output logic         load,
  output logic         up_down,
  output logic [W-1:0] load_val,
`ifdef QUAD_STEP_ERR_CNT_EN
  output logic [7:0]   err_cnt,
`endif
  output logic         err
);

  localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);

  logic [2:0] pin_raw;
  logic [2:0] pin_filt;

  assign pin_raw = {z_in, b_in, a_in};

  // Per-pin two-flop synchroniser followed by a stability filter
  for (genvar i = 0; i < 3; i++) begin : g_pin
    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       filt_q, filt_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      meta_d = pin_raw[i];
      sync_d = meta_q;
      filt_d = filt_q;
      cnt_d  = 8'd0;
      if (sync_q != filt_q) begin
        if (cnt_q == FILT_LAST) begin
          filt_d = sync_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        filt_q <= 1'b0;
        cnt_q  <= 8'd0;
      end else begin
        meta_q <= meta_d;
        sync_q <= sync_d;
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign pin_filt[i] = filt_q;
  end

  logic [1:0]   ab_q, ab_d;
  logic         z_prev_q, z_prev_d;
  logic         ce_q, ce_d;
  logic         load_q, load_d;
  logic         err_q, err_d;
  logic         up_down_q, up_down_d;
  logic [W-1:0] load_val_q, load_val_d;

  logic [1:0] ab_now;
  logic [1:0] ab_diff;
  logic [1:0] up_next;
  logic       illegal;
  logic       step_up;
  logic       qual;
  logic       index_evt;

  always_comb begin
    ab_now  = {pin_filt[0], pin_filt[1]};
    ab_diff = ab_now ^ ab_q;
    illegal = &ab_diff;

    // Forward Gray order is 00 -> 10 -> 11 -> 01 -> 00
    case (ab_q)
      2'b00:   up_next = 2'b10;
      2'b10:   up_next = 2'b11;
      2'b11:   up_next = 2'b01;
      default: up_next = 2'b00;
    endcase
    step_up = (ab_now == up_next);

    case (mode)
      2'b00:   qual = ((ab_q == 2'b00) && (ab_now == 2'b10)) ||
                      ((ab_q == 2'b10) && (ab_now == 2'b00));
      2'b01:   qual = (ab_diff == 2'b10);
      default: qual = (ab_diff != 2'b00) && !illegal;
    endcase

    index_evt = pin_filt[2] & ~z_prev_q & index_en;

    ab_d       = ab_now;
    z_prev_d   = pin_filt[2];
    ce_d       = 1'b0;
    load_d     = 1'b0;
    err_d      = 1'b0;
    up_down_d  = up_down_q;
    load_val_d = load_val_q;

    if (enable) begin
      if (index_evt) begin
        ce_d       = 1'b1;
        load_d     = 1'b1;
        load_val_d = index_val;
      end else if (qual) begin
        ce_d      = 1'b1;
        up_down_d = step_up;
      end
      if (illegal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_q       <= 2'b00;
      z_prev_q   <= 1'b0;
      ce_q       <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      up_down_q  <= 1'b1;
      load_val_q <= '0;
    end else begin
      ab_q       <= ab_d;
      z_prev_q   <= z_prev_d;
      ce_q       <= ce_d;
      load_q     <= load_d;
      err_q      <= err_d;
      up_down_q  <= up_down_d;
      load_val_q <= load_val_d;
    end
  end

  assign ce       = ce_q;
  assign load     = load_q;
  assign err      = err_q;
  assign up_down  = up_down_q;
  assign load_val = load_val_q;

`ifdef QUAD_STEP_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load_q) begin
      err_cnt_d = 8'd0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quad_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_quad_step_ctrl : self-checking bench; expected strobes come from a
//                     Gray-position reference model with fixed pipeline delay.
// Revision 1.0 - initial release
// ============================================================================
module tb_quad_step_ctrl;

  localparam int W        = 16;
  localparam int FILT_LEN = 4;
  localparam int LAT      = FILT_LEN + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   mode;
  logic         a_in, b_in, z_in;
  logic         index_en;
  logic [W-1:0] index_val;
  logic         ce, load, up_down, err;
  logic [W-1:0] load_val;
`ifdef QUAD_STEP_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  quad_step_ctrl #(.W(W), .FILT_LEN(FILT_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .a_in      (a_in),
    .b_in      (b_in),
    .z_in      (z_in),
    .index_en  (index_en),
    .index_val (index_val),
    .ce        (ce),
    .load      (load),
    .up_down   (up_down),
    .load_val  (load_val),
`ifdef QUAD_STEP_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]  t;
    logic         ce;
    logic         ld;
    logic         er;
    logic         ud;
    logic [W-1:0] lv;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];
  ev_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Record every strobe cycle, stamped with the edge index that produced it
  always @(posedge clk) begin
    #1;
    if (ce || load || err) begin
      mon_e.t  = cyc;
      mon_e.ce = ce;
      mon_e.ld = load;
      mon_e.er = err;
      mon_e.ud = up_down;
      mon_e.lv = load_val;
      obs.push_back(mon_e);
    end
  end

  logic [1:0]   ref_ab;
  logic         ref_z;
  logic         m_ud;
  logic [W-1:0] m_lv;

  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pos_ab(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Expected outcome of a settled pin change, visible LAT edges after the drive
  function automatic void model(input logic [1:0] nab, input logic zr, input int t);
    ev_t  e;
    int   p0, d;
    logic q;
    p0   = gray_pos(ref_ab);
    d    = (gray_pos(nab) - p0 + 4) % 4;
    e    = '0;
    e.t  = t;
    if (enable) begin
      if (zr && index_en) begin
        e.ce = 1'b1;
        e.ld = 1'b1;
        m_lv = index_val;
      end
      if (nab != ref_ab) begin
        if (d == 2) begin
          e.er = 1'b1;
        end else if (!e.ld) begin
          if (mode == 2'b00)      q = (p0 == 0 && d == 1) || (p0 == 1 && d == 3);
          else if (mode == 2'b01) q = (nab[1] != ref_ab[1]);
          else                    q = 1'b1;
          if (q) begin
            e.ce = 1'b1;
            m_ud = (d == 1);
          end
        end
      end
    end
    e.ud = m_ud;
    e.lv = m_lv;
    if (e.ce || e.ld || e.er) exp_q.push_back(e);
    ref_ab = nab;
  endfunction

  task automatic drive(input logic na, input logic nb, input logic nz, input int hold);
    a_in = na;
    b_in = nb;
    z_in = nz;
    model({na, nb}, nz & ~ref_z, cyc + LAT);
    ref_z = nz;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset;
    n_checks++;
    if (ce !== 1'b0 || load !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got ce%b ld%b er%b want 000", ce, load, err);
    end
    n_checks++;
    if (up_down !== 1'b1) begin
      n_fail++; $display("FAIL reset_up_down: got %b want 1", up_down);
    end
    n_checks++;
    if (load_val !== '0) begin
      n_fail++; $display("FAIL reset_load_val: got %h want 0000", load_val);
    end
`ifdef QUAD_STEP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    end
`endif
    rst = 1'b0;
    obs.delete();
    repeat (12) @(negedge clk);
    n_checks++;
    if (obs.size() != 0 || up_down !== 1'b1) begin
      n_fail++; $display("FAIL reset_quiet: got %0d strobes ud=%b want 0 strobes ud=1", obs.size(), up_down);
    end
  endtask

  task automatic test_x4_forward;
    obs.delete(); exp_q.delete();
    mode = 2'b10;
    drive(1, 0, 0, 20); drive(1, 1, 0, 20); drive(0, 1, 0, 20); drive(0, 0, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 4) begin
      n_fail++; $display("FAIL x4_fwd count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL x4_fwd ev%0d: got t=%0d ce%b ld%b er%b ud%b lv%h want t=%0d ce%b ld%b er%b ud%b lv%h",
                 i, obs[i].t, obs[i].ce, obs[i].ld, obs[i].er, obs[i].ud, obs[i].lv,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].ld, exp_q[i].er, exp_q[i].ud, exp_q[i].lv);
      end
    end
  endtask

  task automatic test_x2_reverse;
    obs.delete(); exp_q.delete();
    mode = 2'b01;
    drive(0, 1, 0, 20); drive(1, 1, 0, 20); drive(1, 0, 0, 20); drive(0, 0, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 2) begin
      n_fail++; $display("FAIL x2_rev count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL x2_rev ev%0d: got t=%0d ce%b er%b ud%b want t=%0d ce%b er%b ud%b",
                 i, obs[i].t, obs[i].ce, obs[i].er, obs[i].ud,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].er, exp_q[i].ud);
      end
    end
  endtask

  task automatic test_x1;
    obs.delete(); exp_q.delete();
    mode = 2'b00;
    drive(1, 0, 0, 20); drive(1, 1, 0, 20); drive(0, 1, 0, 20); drive(0, 0, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 1) begin
      n_fail++; $display("FAIL x1 count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL x1 ev%0d: got t=%0d ce%b er%b ud%b want t=%0d ce%b er%b ud%b",
                 i, obs[i].t, obs[i].ce, obs[i].er, obs[i].ud,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].er, exp_q[i].ud);
      end
    end
  endtask

  task automatic test_glitch;
    obs.delete(); exp_q.delete();
    mode = 2'b10;
    a_in = 1'b1;
    repeat (FILT_LEN - 1) @(negedge clk);
    a_in = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    n_checks++;
    if (obs.size() != 0) begin
      n_fail++; $display("FAIL glitch_short: got %0d strobes want 0", obs.size());
    end
    drive(1, 0, 0, FILT_LEN); drive(0, 0, 0, LAT + 10);
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL glitch_min count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL glitch_min ev%0d: got t=%0d ce%b ud%b want t=%0d ce%b ud%b",
                 i, obs[i].t, obs[i].ce, obs[i].ud, exp_q[i].t, exp_q[i].ce, exp_q[i].ud);
      end
    end
  endtask

  task automatic test_illegal;
    obs.delete(); exp_q.delete();
    mode = 2'b10;
    drive(1, 1, 0, 20); drive(0, 1, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 2) begin
      n_fail++; $display("FAIL illegal count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL illegal ev%0d: got t=%0d ce%b er%b ud%b want t=%0d ce%b er%b ud%b",
                 i, obs[i].t, obs[i].ce, obs[i].er, obs[i].ud,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].er, exp_q[i].ud);
      end
    end
`ifdef QUAD_STEP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL err_cnt_inc: got %0d want 1", err_cnt);
    end
`endif
  endtask

  task automatic test_index;
    obs.delete(); exp_q.delete();
    mode      = 2'b10;
    index_en  = 1'b1;
    index_val = 16'h1234;
    drive(1, 1, 1, 20);
    drive(1, 1, 0, 20);
    index_en  = 1'b0;
    index_val = 16'hBEEF;
    drive(1, 1, 1, 20);
    drive(1, 1, 0, 20);
    drive(0, 1, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 2) begin
      n_fail++; $display("FAIL index count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL index ev%0d: got t=%0d ce%b ld%b ud%b lv%h want t=%0d ce%b ld%b ud%b lv%h",
                 i, obs[i].t, obs[i].ce, obs[i].ld, obs[i].ud, obs[i].lv,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].ld, exp_q[i].ud, exp_q[i].lv);
      end
    end
`ifdef QUAD_STEP_ERR_CNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL err_cnt_clr: got %0d want 0", err_cnt);
    end
`endif
  endtask

  task automatic test_enable;
    obs.delete(); exp_q.delete();
    mode     = 2'b10;
    enable   = 1'b0;
    index_en = 1'b1;
    drive(0, 0, 1, 20);
    drive(0, 0, 0, 20);
    enable   = 1'b1;
    index_en = 1'b0;
    drive(1, 0, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 1) begin
      n_fail++; $display("FAIL enable count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL enable ev%0d: got t=%0d ce%b er%b ud%b want t=%0d ce%b er%b ud%b",
                 i, obs[i].t, obs[i].ce, obs[i].er, obs[i].ud,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].er, exp_q[i].ud);
      end
    end
  endtask

  task automatic test_mid_reset;
    obs.delete(); exp_q.delete();
    mode = 2'b10;
    drive(1, 1, 0, 20); drive(1, 0, 0, 20);
    n_checks++;
    if (up_down !== m_ud || up_down !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset_dir: got %b want 0", up_down);
    end
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    #1;
    n_checks++;
    if (up_down !== 1'b1 || ce !== 1'b0 || load_val !== '0) begin
      n_fail++; $display("FAIL mid_reset: got ud%b ce%b lv%h want ud1 ce0 lv0000", up_down, ce, load_val);
    end
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    ref_ab = 2'b00;
    ref_z  = 1'b0;
    m_ud   = 1'b1;
    m_lv   = '0;
    obs.delete(); exp_q.delete();
    repeat (LAT + 5) @(negedge clk);
    drive(1, 0, 0, 20);
    n_checks++;
    if (obs.size() != exp_q.size() || obs.size() != 1) begin
      n_fail++; $display("FAIL post_reset count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL post_reset ev%0d: got t=%0d ce%b ud%b want t=%0d ce%b ud%b",
                 i, obs[i].t, obs[i].ce, obs[i].ud, exp_q[i].t, exp_q[i].ce, exp_q[i].ud);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] nab;
    int         r, p;
    obs.delete(); exp_q.delete();
    for (int k = 0; k < 80; k++) begin
      mode      = 2'($urandom_range(0, 3));
      enable    = ($urandom_range(0, 7) != 0);
      index_en  = 1'($urandom_range(0, 1));
      index_val = W'($urandom);
      r = $urandom_range(0, 9);
      p = gray_pos(ref_ab);
      if (r < 4)      p = (p + 1) % 4;
      else if (r < 8) p = (p + 3) % 4;
      else if (r < 9) p = (p + 2) % 4;
      nab = pos_ab(p);
      drive(nab[1], nab[0], ($urandom_range(0, 3) == 0) ? ~ref_z : ref_z,
            LAT + $urandom_range(0, 4));
    end
    enable = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    n_checks++;
    if (obs.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs.size()) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random ev%0d: got t=%0d ce%b ld%b er%b ud%b lv%h want t=%0d ce%b ld%b er%b ud%b lv%h",
                 i, obs[i].t, obs[i].ce, obs[i].ld, obs[i].er, obs[i].ud, obs[i].lv,
                 exp_q[i].t, exp_q[i].ce, exp_q[i].ld, exp_q[i].er, exp_q[i].ud, exp_q[i].lv);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    mode      = 2'b10;
    a_in      = 1'b0;
    b_in      = 1'b0;
    z_in      = 1'b0;
    index_en  = 1'b0;
    index_val = '0;
    ref_ab    = 2'b00;
    ref_z     = 1'b0;
    m_ud      = 1'b1;
    m_lv      = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_x4_forward();
    test_x2_reverse();
    test_x1();
    test_glitch();
    test_illegal();
    test_index();
    test_enable();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quad_step_ctrl.md
Name: quad_step_ctrl

Overview:
Quadrature encoder front end that drives the control inputs of the team's loadable up/down counter (ce, load, up_down, load_val).
- Synchronises and glitch-filters raw A/B/Z encoder pins.
- Decodes A/B into single-cycle count strobes with direction, at x1/x2/x4 resolution.
- Converts index (Z) edges into a load request.
- Flags illegal A/B transitions.

Parameters:
W, 16, width of load_val; must match downstream counter W.
FILT_LEN, 4, consecutive stable cycles required before a filtered pin changes; legal range 1..255.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  1 = strobes (ce/load/err) may be generated.
mode  input  2  00 = x1, 01 = x2, 10/11 = x4 decode.
a_in  input  1  raw encoder A, asynchronous.
b_in  input  1  raw encoder B, asynchronous.
z_in  input  1  raw encoder index, asynchronous.
index_en  input  1  1 = Z rising edge produces load.
index_val  input  W  value presented on load_val at an index event.
ce  output  1  one-cycle count-enable strobe.
load  output  1  one-cycle load strobe; always accompanied by ce=1.
up_down  output  1  1 = count up, 0 = count down.
load_val  output  W  registered copy of index_val captured at the index event.
err  output  1  one-cycle illegal-transition strobe.

Behaviour:
- Reset (async, active-high): all sync/filter flops 0, filtered A/B/Z = 0, ce = load = err = 0, up_down = 1, load_val = 0, filter counters 0.
- Synchroniser: two flops per pin (a_in, b_in, z_in).
- Filter, per pin: counter increments while synced value != filtered value, clears when equal.
  - Filtered value takes the synced value on the edge where the counter reaches FILT_LEN; the counter clears at the same edge.
  - Pulses shorter than FILT_LEN cycles never propagate.
- Latency: ce/load/err are registered. A pin change sampled at edge e0 produces a strobe high during the cycle after edge e0+FILT_LEN+2.
- Decode, on filtered state change (prev AB -> new AB, Gray sequence 00->10->11->01->00 = up, reverse = down):
  - x4: every legal transition -> ce=1, up_down = direction.
  - x2: only transitions where A changes -> ce.
  - x1: only 00->10 (up) and 10->00 (down) -> ce.
- Illegal transition (A and B filtered values change on the same edge): err=1 for one cycle, no ce, up_down unchanged; new AB is still adopted as the reference state.
- Index: filtered Z 0->1 with index_en=1 -> load=1, ce=1, load_val <= index_val (same edge).
  - A step coinciding with the index event is discarded; the load takes priority.
  - up_down is unchanged by an index event.
- up_down holds its last direction when no step occurs.
- enable=0: ce, load and err are forced 0 and events are discarded. Sync, filters and the reference AB state keep tracking, so re-enabling never emits a stale step.
- mode changes take effect on the next decoded transition; no pipeline flush.
- Mid-operation reset returns to the reset state immediately. After release, the first step is produced only after a filtered change away from AB=00.

Optional Feature:
Macro QUAD_STEP_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0].
  - Increments on each err strobe, saturates at 255.
  - Cleared by rst and by a load strobe.
- Undefined: port absent, no counter logic; err strobe behaviour is identical in both builds.

Test Plan:
- FILT_LEN=4, mode=10, A/B stepped 00->10->11->01->00 with 20 cycles per state -> four ce pulses with up_down=1; each ce arrives 6 edges after the sampling edge of the pin change.
- Same sequence reversed, mode=01 -> exactly two ce pulses, up_down=0.
- mode=00, one full forward cycle -> one ce at the 00->10 transition; err never asserted.
- Glitch: a_in high for 3 cycles with FILT_LEN=4 -> no ce, filtered A stays 0; hold for 4 cycles -> one ce.
- Simultaneous A and B change 00->11 -> err=1 for one cycle, ce=0; with the macro defined err_cnt=1; a following 11->01 is counted as up.
- index_en=1, index_val=16'h1234, Z rising edge coinciding with an A step -> one cycle with load=1, ce=1, load_val=16'h1234, no separate step strobe; with index_en=0 -> no load.
